// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_pkg
// Description : Shared types and constants for the sequential radix-2 Booth
//               multiplier (controller and datapath).
//               - state_t    : controller state encoding
//               - BOOTH_ADD  : {q0,q_m1} pair that selects A <= A + M
//               - BOOTH_SUB  : {q0,q_m1} pair that selects A <= A - M
//               - MULT_WIDTH : default operand width / Booth iteration count
// Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

    localparam int MULT_WIDTH = 4;

    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        EVAL  = 3'd2,
        ADD   = 3'd3,
        SUB   = 3'd4,
        SHIFT = 3'd5,
        DONE  = 3'd6
    } state_t;

endpackage : mult_pkg
`default_nettype wire

// File: rtl/mult_iter_counter.sv
`default_nettype none
// ============================================================================
// Module      : mult_iter_counter
// Description : Loadable down-counter tracking the remaining Booth iterations.
//               Load has priority over decrement; the count saturates at zero.
// Ports       : clk        - clock, rising edge
//               rst        - synchronous active-high reset (count -> 0)
//               i_load     - load i_load_val
//               i_load_val - value to load
//               i_dec      - decrement by one (ignored at zero)
//               o_cnt      - current count
//               o_zero     - count == 0
//               o_one      - count == 1
// Revision    : 1.0 - initial release
// ============================================================================
module mult_iter_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_zero,
    output logic             o_one
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            // Guarded so the count can never wrap below zero.
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_cnt  = r_cnt;
    assign o_zero = (r_cnt == '0);
    assign o_one  = (r_cnt == CNT_W'(1));

endmodule : mult_iter_counter
`default_nettype wire

// File: rtl/booth_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : booth_mult_ctrl
// Description : Control unit for a sequential radix-2 Booth multiplier.
//               Sequences LOAD, then WIDTH iterations of EVAL/[ADD|SUB]/SHIFT,
//               then a one-cycle DONE. All outputs are registered alongside
//               the state, so nothing depends combinationally on the inputs.
// Ports       : clk      - clock, rising edge
//               rst      - synchronous active-high reset
//               start    - begin a multiplication (sampled only in IDLE)
//               q0       - multiplier-register LSB from the datapath
//               q_m1     - Q(-1) flip-flop from the datapath
//               load     - strobe: load operands, clear A and Q(-1)
//               add      - strobe: A <= A + M
//               sub      - strobe: A <= A - M
//               shift    - strobe: arithmetic right shift of {A,Q,Q(-1)}
//               busy     - high from LOAD through DONE inclusive
//               done     - one-cycle pulse, product valid this cycle
//               iter_cnt - remaining iterations
// Revision    : 1.0 - initial release
// ============================================================================
module booth_mult_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             q0,
    input  logic             q_m1,
    output logic             load,
    output logic             add,
    output logic             sub,
    output logic             shift,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] iter_cnt
);

    localparam logic [CNT_W-1:0] C_ITER_INIT = CNT_W'(WIDTH);

    state_t r_state;
    logic   r_load;
    logic   r_add;
    logic   r_sub;
    logic   r_shift;
    logic   r_busy;
    logic   r_done;

    logic   w_cnt_load;
    logic   w_cnt_dec;
    logic   w_cnt_zero;
    logic   w_cnt_one;

    // The counter follows the registered state: it is loaded on the edge
    // leaving LOAD and decremented on the edge leaving SHIFT.
    assign w_cnt_load = (r_state == LOAD);
    assign w_cnt_dec  = (r_state == SHIFT);

    mult_iter_counter #(
        .CNT_W (CNT_W)
    ) u_iter_counter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_cnt_load),
        .i_load_val (C_ITER_INIT),
        .i_dec      (w_cnt_dec),
        .o_cnt      (iter_cnt),
        .o_zero     (w_cnt_zero),
        .o_one      (w_cnt_one)
    );

    // Each branch assigns the outputs belonging to the state being entered,
    // so the registered outputs always describe the registered state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_load  <= 1'b0;
            r_add   <= 1'b0;
            r_sub   <= 1'b0;
            r_shift <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_load  <= 1'b0;
            r_add   <= 1'b0;
            r_sub   <= 1'b0;
            r_shift <= 1'b0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= LOAD;
                        r_load  <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                LOAD: begin
                    r_state <= EVAL;
                end
                EVAL: begin
                    case ({q0, q_m1})
                        BOOTH_ADD: begin
                            r_state <= ADD;
                            r_add   <= 1'b1;
                        end
                        BOOTH_SUB: begin
                            r_state <= SUB;
                            r_sub   <= 1'b1;
                        end
                        default: begin
                            r_state <= SHIFT;
                            r_shift <= 1'b1;
                        end
                    endcase
                end
                ADD, SUB: begin
                    r_state <= SHIFT;
                    r_shift <= 1'b1;
                end
                SHIFT: begin
                    // The zero term only matters if the count was somehow
                    // lost; it keeps the FSM from looping forever.
                    if (w_cnt_one || w_cnt_zero) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= EVAL;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign load  = r_load;
    assign add   = r_add;
    assign sub   = r_sub;
    assign shift = r_shift;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule : booth_mult_ctrl
`default_nettype wire

// File: tb/tb_booth_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth_mult_ctrl
// Description : Self-checking bench for booth_mult_ctrl. A behavioural model
//               expands each accepted start into the list of per-cycle
//               outputs implied by the Booth recoding rule; every cycle the
//               DUT outputs are compared against the head of that list.
//               Scripted operations additionally pin the strobe trace and
//               latency against hand-written literals.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_mult_ctrl;

    localparam int WIDTH = 4;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          q0;
    logic          q_m1;
    logic          load;
    logic          add;
    logic          sub;
    logic          shift;
    logic          busy;
    logic          done;
    logic [CW-1:0] iter_cnt;

    booth_mult_ctrl #(
        .WIDTH (WIDTH),
        .CNT_W (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .q0       (q0),
        .q_m1     (q_m1),
        .load     (load),
        .add      (add),
        .sub      (sub),
        .shift    (shift),
        .busy     (busy),
        .done     (done),
        .iter_cnt (iter_cnt)
    );

    always #5 clk = ~clk;

    // strb = {load, add, sub, shift}; eval/pair tell the driver what the
    // datapath must present while the controller is evaluating.
    typedef struct packed {
        logic [3:0]    strb;
        logic          busy;
        logic          done;
        logic [CW-1:0] cnt;
        logic          eval;
        logic [1:0]    pair;
    } exp_t;

    localparam exp_t IDLE_E = '0;

    exp_t  exp_q[$];
    exp_t  cur        = IDLE_E;
    bit    was_idle   = 1'b0;
    bit    rand_pairs = 1'b0;
    bit    seen_done  = 1'b0;
    logic [7:0] nxt_pairs = 8'h00;
    string trace      = "";
    int    n_checks   = 0;
    int    n_err      = 0;
    int    n_done     = 0;
    int    cyc        = 0;

    function automatic exp_t mk(input logic [3:0] s, input logic b, input logic d,
                                input logic [CW-1:0] c, input logic e, input logic [1:0] p);
        exp_t r;
        r = {s, b, d, c, e, p};
        return r;
    endfunction

    // Expand one multiplication: LOAD, then per pair EVAL, optional ADD/SUB
    // (01 adds M, 10 subtracts M), SHIFT; then DONE.
    task automatic push_op();
        logic [1:0]    p;
        logic [CW-1:0] c;
        if (rand_pairs) nxt_pairs = 8'($urandom);
        trace     = "";
        seen_done = 1'b0;
        exp_q.push_back(mk(4'b1000, 1'b1, 1'b0, '0, 1'b0, 2'b00));
        for (int i = 0; i < WIDTH; i++) begin
            p = nxt_pairs[7 - 2*i -: 2];
            c = CW'(WIDTH - i);
            exp_q.push_back(mk(4'b0000, 1'b1, 1'b0, c, 1'b1, p));
            if (p == 2'b01)
                exp_q.push_back(mk(4'b0100, 1'b1, 1'b0, c, 1'b0, 2'b00));
            else if (p == 2'b10)
                exp_q.push_back(mk(4'b0010, 1'b1, 1'b0, c, 1'b0, 2'b00));
            exp_q.push_back(mk(4'b0001, 1'b1, 1'b0, c, 1'b0, 2'b00));
        end
        exp_q.push_back(mk(4'b0000, 1'b1, 1'b1, '0, 1'b0, 2'b00));
    endtask

    task automatic compare();
        exp_t       e;
        logic [8:0] got;
        logic [8:0] want;
        string      ch;
        cyc++;
        if (exp_q.size() == 0) begin
            e        = IDLE_E;
            was_idle = 1'b1;
        end else begin
            e        = exp_q.pop_front();
            was_idle = 1'b0;
        end
        cur  = e;
        got  = {load, add, sub, shift, busy, done, iter_cnt};
        want = {e.strb, e.busy, e.done, e.cnt};
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL model_cmp cycle=%0d lash_busy_done_cnt got=%b required=%b", cyc, got, want);
        end
        n_checks++;
        if (!$onehot0({load, add, sub, shift})) begin
            n_err++;
            $display("FAIL strobe_excl cycle=%0d got=%b required=onehot0", cyc, {load, add, sub, shift});
        end
        if (done)       ch = "D";
        else if (load)  ch = "L";
        else if (add)   ch = "A";
        else if (sub)   ch = "U";
        else if (shift) ch = "H";
        else            ch = "-";
        if (trace.len() < 40) trace = {trace, ch};
        if (done) begin
            seen_done = 1'b1;
            n_done++;
        end
    endtask

    // Drive inputs for the coming edge, advance the model, then check the
    // resulting cycle on the falling edge.
    task automatic tick(input logic st, input logic rs);
        start = st;
        rst   = rs;
        if (cur.eval) {q0, q_m1} = cur.pair;
        else          {q0, q_m1} = 2'($urandom_range(0, 3));
        if (rs)                     exp_q.delete();
        else if (was_idle && st)    push_op();
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 30 && !(was_idle && exp_q.size() == 0); i++) tick(1'b0, 1'b0);
    endtask

    task automatic run_op(input string name, input logic [7:0] pairs,
                          input string want_trace, input int want_lat, input bit poke);
        wait_idle();
        rand_pairs = 1'b0;
        nxt_pairs  = pairs;
        tick(1'b1, 1'b0);
        for (int i = 0; i < 20 && !seen_done; i++) tick(poke && (i % 3 == 1), 1'b0);
        n_checks++;
        if (!seen_done) begin
            n_err++;
            $display("FAIL %s_timeout got=no_done required=done_within_20", name);
        end
        n_checks++;
        if (trace != want_trace) begin
            n_err++;
            $display("FAIL %s_trace got=%s required=%s", name, trace, want_trace);
        end
        n_checks++;
        if (trace.len() != want_lat) begin
            n_err++;
            $display("FAIL %s_latency got=%0d required=%0d", name, trace.len(), want_lat);
        end
        tick(1'b0, 1'b0);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL %s_after_done got=busy%b_done%b required=busy0_done0", name, busy, done);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        q0    = 1'b0;
        q_m1  = 1'b0;

        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        n_checks++;
        if ({load, add, sub, shift, busy, done, iter_cnt} !== 9'd0) begin
            n_err++;
            $display("FAIL reset_state got=%b required=%b", {load, add, sub, shift, busy, done, iter_cnt}, 9'd0);
        end

        // Booth pairs listed first-iteration first, two bits each.
        run_op("scripted", 8'b10_11_01_00, "L-UH-H-AH-HD", 12, 1'b0);
        run_op("min_lat",  8'b00_00_00_00, "L-H-H-H-HD",   10, 1'b0);
        run_op("max_lat",  8'b10_01_10_01, "L-UH-AH-UH-AHD", 14, 1'b1);

        // Reset while the controller sits in ADD; start during reset is ignored.
        wait_idle();
        rand_pairs = 1'b0;
        nxt_pairs  = 8'b01_00_00_00;
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        n_checks++;
        if (add !== 1'b1) begin
            n_err++;
            $display("FAIL reset_setup_add got=%b required=1", add);
        end
        tick(1'b0, 1'b1);
        n_checks++;
        if ({load, add, sub, shift, busy, done, iter_cnt} !== 9'd0) begin
            n_err++;
            $display("FAIL reset_midrun got=%b required=%b", {load, add, sub, shift, busy, done, iter_cnt}, 9'd0);
        end
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b0);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_no_done got=busy%b_done%b required=busy0_done0", busy, done);
        end
        run_op("post_reset", 8'b00_00_00_00, "L-H-H-H-HD", 10, 1'b0);

        // start held high: 10-cycle operations separated by one IDLE cycle
        // complete at cycles 10, 21 and 32 of a 40-cycle window.
        wait_idle();
        rand_pairs = 1'b0;
        nxt_pairs  = 8'b00_00_00_00;
        n_done     = 0;
        for (int i = 0; i < 40; i++) tick(1'b1, 1'b0);
        n_checks++;
        if (n_done != 3) begin
            n_err++;
            $display("FAIL held_start_dones got=%0d required=3", n_done);
        end

        // Random pairs, random start activity (including while busy).
        wait_idle();
        rand_pairs = 1'b1;
        n_done     = 0;
        for (int i = 0; i < 600; i++) tick(($urandom_range(0, 3) == 0), 1'b0);
        n_checks++;
        if (n_done < 10) begin
            n_err++;
            $display("FAIL random_activity got=%0d required=at_least_10", n_done);
        end
        wait_idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_booth_mult_ctrl
`default_nettype wire

// File: doc/booth_mult_ctrl.md
Name: booth_mult_ctrl

Overview:
- Control unit for the sequential (radix-2 Booth) multiplier.
- Sits directly upstream of the accumulator/multiplier shift registers and the add/sub unit; drives their load, shift and add/sub strobes.
- Accepts a start/done handshake from the host and sequences exactly WIDTH Booth iterations.
- Reads the multiplier LSB and the Q(-1) bit back from the datapath each iteration.

Parameters:
- WIDTH, 4, operand width in bits = number of Booth iterations.
- CNT_W, $clog2(WIDTH+1), width of the iteration counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a multiplication; sampled only in IDLE.
- q0  input  1  current multiplier-register LSB from datapath.
- q_m1  input  1  current Q(-1) flip-flop from datapath.
- load  output  1  one-cycle strobe: datapath loads operands, clears A and Q(-1).
- add  output  1  one-cycle strobe: A <= A + M.
- sub  output  1  one-cycle strobe: A <= A - M.
- shift  output  1  one-cycle strobe: arithmetic right shift of {A,Q,Q(-1)}.
- busy  output  1  high from LOAD through DONE inclusive.
- done  output  1  one-cycle pulse; the product is valid in the datapath this cycle.
- iter_cnt  output  CNT_W  remaining iterations (debug/observability).

Behaviour:
- Reset: all outputs 0, iter_cnt = 0, state = IDLE. rst dominates every other input on any cycle, including mid-operation. Reset during an operation abandons it with no done pulse.
- Outputs are Moore: decoded from registered state only, with no combinational path from start, q0 or q_m1.
- Invariant: at most one of load/add/sub/shift is high in any cycle.
- States and transitions:
  - IDLE: busy = 0. If start = 1 at the edge, go to LOAD; otherwise stay.
  - LOAD: load = 1, busy = 1. Set iter_cnt <= WIDTH, then go to EVAL.
  - EVAL: no strobe. Sample {q0,q_m1}: 01 goes to ADD, 10 goes to SUB, 00 or 11 goes to SHIFT.
  - ADD: add = 1, then go to SHIFT.
  - SUB: sub = 1, then go to SHIFT.
  - SHIFT: shift = 1, iter_cnt <= iter_cnt - 1. If iter_cnt == 1, go to DONE; otherwise go to EVAL.
  - DONE: done = 1, busy = 1, then go to IDLE.
- Timing: per iteration, 2 cycles (EVAL, SHIFT) or 3 cycles (EVAL, ADD/SUB, SHIFT).
  - Total from the start edge to the done cycle = 1 (LOAD) + sum over iterations + 1 (DONE).
  - WIDTH = 4: minimum 10 cycles, maximum 14 cycles.
- start while busy: ignored, not queued. start held high continuously starts a new operation on the first edge after DONE→IDLE, i.e. one IDLE cycle between operations.
- iter_cnt never wraps: it decrements only in SHIFT and only from values ≥ 1.
- q0/q_m1 are don't-care outside EVAL.
- Illegal or unreachable state encodings go to IDLE on the next edge with all strobes 0.

Decomposition:
- Package mult_pkg holds:
  - typedef enum state_t {IDLE, LOAD, EVAL, ADD, SUB, SHIFT, DONE};
  - the Booth pair constants BOOTH_ADD = 2'b01 and BOOTH_SUB = 2'b10;
  - the default WIDTH constant, shared with the datapath.
- One sub-module, mult_iter_counter: loadable down-counter (load value, dec enable, zero/one flags, synchronous reset).
- The FSM stays in booth_mult_ctrl.

Test Plan:
- Reset: assert rst for 2 cycles mid-run (in the ADD state) → next cycle all strobes 0, busy = 0, iter_cnt = 0; a following start behaves normally.
- Scripted Booth sequence: WIDTH = 4, start pulse; bench drives {q0,q_m1} at each EVAL as 10, 11, 01, 00.
  - Required strobes: LOAD, -, SUB, SHIFT, -, SHIFT, -, ADD, SHIFT, -, SHIFT, DONE.
  - done lands in cycle 12 after the start edge; iter_cnt goes 4, 3, 2, 1, 0.
- Minimum latency: {q0,q_m1} = 00 at every EVAL → 4 shifts, no add/sub, done 10 cycles after start.
- Maximum latency: {q0,q_m1} = 10, 01, 10, 01 → alternating SUB/ADD, done 14 cycles after start.
- start held high for 40 cycles → back-to-back operations, each separated by exactly one IDLE cycle; a start pulse during busy has no effect on strobe count or timing.
- Full-run assertions: load/add/sub/shift are mutually exclusive, exactly 4 shift pulses and 1 load pulse per operation, done width is 1 cycle, and busy = 0 in the cycle after done.
